// File: rtl/btn_tally_counter_if.sv
// Button/count bundle between the board-facing tally counter and its user.
// The master drives the raw buttons and the slave (the counter) returns the count and pulses.
interface btn_tally_counter_if;
  logic        inUp;
  logic        inDown;
  logic        inClr;
  logic [13:0] outBin;
  logic        outPress;
  logic        outWrap;

  modport master (
    output inUp, inDown, inClr,
    input  outBin, outPress, outWrap
  );

  modport slave (
    input  inUp, inDown, inClr,
    output outBin, outPress, outWrap
  );
endinterface

// File: rtl/btn_tally_counter.sv
// Push-button tally counter: synchronises and debounces up/down/clear buttons and keeps
// a registered 0..MAX_COUNT count for the 7-segment display driver.
module btn_tally_counter #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20,
  parameter int MAX_COUNT  = 9999,
  parameter bit WRAP       = 1'b1
) (
  input logic                 inClk,
  input logic                 inRstN,
  btn_tally_counter_if.slave  bus
);

  localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CYCLES - 1);
  localparam logic [13:0]      MaxVal  = 14'(MAX_COUNT);

  // Button index: 0 = up, 1 = down, 2 = clear.
  logic [2:0]       rawBtn;
  logic [2:0]       sync1_q, sync2_q;
  logic [1:0]       syncValid_q;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       stableDly_q;
  logic [2:0]       armed_q, armed_d;
  logic [DEB_W-1:0] debCnt_q [3];
  logic [DEB_W-1:0] debCnt_d [3];
  logic [2:0]       pressEv;
  logic [13:0]      bin_q, bin_d;
  logic             press_q, press_d;
  logic             wrap_q, wrap_d;

  assign rawBtn = {bus.inClr, bus.inDown, bus.inUp};

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      syncValid_q <= '0;
      stable_q    <= '0;
      stableDly_q <= '0;
      armed_q     <= '0;
      for (int b = 0; b < 3; b++) begin
        debCnt_q[b] <= '0;
      end
    end else begin
      sync1_q     <= rawBtn;
      sync2_q     <= sync1_q;
      syncValid_q <= {syncValid_q[0], 1'b1};
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      armed_q     <= armed_d;
      for (int b = 0; b < 3; b++) begin
        debCnt_q[b] <= debCnt_d[b];
      end
    end
  end

  // A button is armed once a genuine released sample reaches the synchroniser output, so a
  // button held through reset only counts after it has been let go and pressed again.
  always_comb begin
    stable_d = stable_q;
    armed_d  = armed_q | ({3{syncValid_q[1]}} & ~sync2_q);
    for (int b = 0; b < 3; b++) begin
      debCnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (debCnt_q[b] == DebLast) begin
          stable_d[b] = ~stable_q[b];
        end else begin
          debCnt_d[b] = debCnt_q[b] + DEB_W'(1);
        end
      end
    end
  end

  assign pressEv = stable_q & ~stableDly_q & armed_q;

  // Clear beats everything; up and down together cancel; limits are tested before the add/sub.
  always_comb begin
    bin_d   = bin_q;
    press_d = 1'b0;
    wrap_d  = 1'b0;
    if (pressEv[2]) begin
      bin_d   = '0;
      press_d = 1'b1;
    end else if (pressEv[0] ^ pressEv[1]) begin
      press_d = 1'b1;
      if (pressEv[0]) begin
        if (bin_q < MaxVal) begin
          bin_d = bin_q + 14'd1;
        end else if (WRAP) begin
          bin_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (bin_q != 14'd0) begin
          bin_d = bin_q - 14'd1;
        end else if (WRAP) begin
          bin_d  = MaxVal;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      bin_q   <= '0;
      press_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      press_q <= press_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.outBin   = bin_q;
  assign bus.outPress = press_q;
  assign bus.outWrap  = wrap_q;

endmodule

// File: tb/tb_btn_tally_counter.sv
// Bench for btn_tally_counter: a wrapping and a saturating instance share the same buttons and
// are compared every cycle against a queue-based reference model plus table and corner sequences.
module tb_btn_tally_counter;
  localparam int N    = 4;
  localparam int MAXC = 9;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  logic up   = 1'b0;
  logic down = 1'b0;
  logic clr  = 1'b0;

  int checks = 0;
  int errors = 0;
  int pressCntW, wrapCntW, pressCntS, wrapCntS;

  bit hist [3][$];
  bit mStable [3];
  bit mArmed [3];
  bit mPend [3];
  int mEdge;
  int mBin [2];
  bit mPress [2];
  bit mWrap [2];

  typedef struct {
    bit u, d, c;
    int expW, expS, expPressW, expWrapW;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  btn_tally_counter_if ifW ();
  btn_tally_counter_if ifS ();

  assign ifW.inUp   = up;
  assign ifW.inDown = down;
  assign ifW.inClr  = clr;
  assign ifS.inUp   = up;
  assign ifS.inDown = down;
  assign ifS.inClr  = clr;

  btn_tally_counter #(.DEB_CYCLES(N), .DEB_W(3), .MAX_COUNT(MAXC), .WRAP(1'b1)) dutW (
    .inClk(clk), .inRstN(rstN), .bus(ifW)
  );

  btn_tally_counter #(.DEB_CYCLES(N), .DEB_W(3), .MAX_COUNT(MAXC), .WRAP(1'b0)) dutS (
    .inClk(clk), .inRstN(rstN), .bus(ifS)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reset view of the model: synchroniser outputs read as low, so history is prefilled with zeros.
  task automatic modelReset();
    for (int b = 0; b < 3; b++) begin
      hist[b].delete();
      repeat (N + 1) hist[b].push_back(1'b0);
      mStable[b] = 1'b0;
      mArmed[b]  = 1'b0;
      mPend[b]   = 1'b0;
    end
    mEdge = 0;
    for (int d = 0; d < 2; d++) begin
      mBin[d]   = 0;
      mPress[d] = 1'b0;
      mWrap[d]  = 1'b0;
    end
  endtask

  // One rising edge: apply last edge's accepted presses, then accept new levels that have been
  // seen for N consecutive synchronised samples (sample k reaches the debouncer two edges later).
  task automatic modelStep();
    bit raw [3];
    bit allFlip;
    bit rose;
    int nxt;
    raw[0] = up;
    raw[1] = down;
    raw[2] = clr;
    for (int d = 0; d < 2; d++) begin
      mPress[d] = 1'b0;
      mWrap[d]  = 1'b0;
      if (mPend[2]) begin
        mBin[d]   = 0;
        mPress[d] = 1'b1;
      end else if (mPend[0] != mPend[1]) begin
        mPress[d] = 1'b1;
        nxt = mBin[d] + (mPend[0] ? 1 : -1);
        if (nxt >= 0 && nxt <= MAXC) begin
          mBin[d] = nxt;
        end else if (d == 0) begin
          mBin[d] = (nxt + MAXC + 1) % (MAXC + 1);
          mWrap[d] = 1'b1;
        end
      end
    end
    mEdge++;
    for (int b = 0; b < 3; b++) begin
      hist[b].push_back(raw[b]);
      if (hist[b].size() > N + 2) void'(hist[b].pop_front());
      allFlip = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (hist[b][i] == mStable[b]) allFlip = 1'b0;
      end
      if (mEdge >= 3 && hist[b][N - 1] == 1'b0) mArmed[b] = 1'b1;
      rose = allFlip && !mStable[b];
      if (allFlip) mStable[b] = !mStable[b];
      mPend[b] = rose && mArmed[b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstN) modelStep();
    #1;
    check("binW",   int'(ifW.outBin),   mBin[0]);
    check("pressW", int'(ifW.outPress), int'(mPress[0]));
    check("wrapW",  int'(ifW.outWrap),  int'(mWrap[0]));
    check("binS",   int'(ifS.outBin),   mBin[1]);
    check("pressS", int'(ifS.outPress), int'(mPress[1]));
    check("wrapS",  int'(ifS.outWrap),  int'(mWrap[1]));
    pressCntW += int'(ifW.outPress);
    wrapCntW  += int'(ifW.outWrap);
    pressCntS += int'(ifS.outPress);
    wrapCntS  += int'(ifS.outWrap);
  endtask

  task automatic clearCounts();
    pressCntW = 0;
    wrapCntW  = 0;
    pressCntS = 0;
    wrapCntS  = 0;
  endtask

  task automatic applyStimulus(input bit u, input bit d, input bit c, input int hold, input int rel);
    up   = u;
    down = d;
    clr  = c;
    repeat (hold) tick();
    up   = 1'b0;
    down = 1'b0;
    clr  = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic checkOutput(input string name, input int expW, input int expS);
    check({name, "W"}, int'(ifW.outBin), expW);
    check({name, "S"}, int'(ifS.outBin), expS);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 1, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 0, 1, 1, 1, 0};
    vecs[2]  = '{1, 0, 0, 2, 2, 1, 0};
    vecs[3]  = '{0, 1, 0, 1, 1, 1, 0};
    vecs[4]  = '{1, 1, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 9, 0, 1, 1};
    vecs[7]  = '{1, 0, 0, 0, 1, 1, 1};
    vecs[8]  = '{0, 1, 0, 9, 0, 1, 1};
    vecs[9]  = '{1, 0, 1, 0, 0, 1, 0};
    vecs[10] = '{0, 1, 1, 0, 0, 1, 0};
    vecs[11] = '{1, 0, 0, 1, 1, 1, 0};

    clearCounts();
    modelReset();
    #2 rstN = 1'b0;
    repeat (3) tick();
    rstN = 1'b0;
    rstN = 1'b1;
    repeat (50) tick();
    checkOutput("idleBin", 0, 0);
    check("idlePressCnt", pressCntW + pressCntS, 0);

    // Clean press: count changes on edge 7 only, one event however long it is held.
    clearCounts();
    up = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("cleanPress@%0d", e), int'(ifW.outPress), int'(e == 7));
    end
    repeat (23) tick();
    up = 1'b0;
    repeat (15) tick();
    check("cleanPressCnt", pressCntW, 1);
    checkOutput("cleanBin", 1, 1);

    // Bounce for 12 cycles, then settle high: one increment, 7 edges after settling.
    clearCounts();
    for (int i = 0; i < 12; i++) begin
      up = ((i / 2) % 2) == 0;
      tick();
    end
    up = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("bouncePress@%0d", e), int'(ifW.outPress), int'(e == 7));
    end
    repeat (10) tick();
    up = 1'b0;
    repeat (15) tick();
    check("bouncePressCnt", pressCntW, 1);
    checkOutput("bounceBin", 2, 2);

    for (int v = 0; v < 12; v++) begin
      clearCounts();
      applyStimulus(vecs[v].u, vecs[v].d, vecs[v].c, 10, 10);
      checkOutput($sformatf("vec%0d_bin", v), vecs[v].expW, vecs[v].expS);
      check($sformatf("vec%0d_pressW", v), pressCntW, vecs[v].expPressW);
      check($sformatf("vec%0d_wrapW", v), wrapCntW, vecs[v].expWrapW);
      check($sformatf("vec%0d_wrapS", v), wrapCntS, 0);
    end

    // Limits: nine ups to the top, the tenth wraps (or saturates with a press pulse).
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
    repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
    checkOutput("topBin", 9, 9);
    up = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("wrapPulseW@%0d", e), int'(ifW.outWrap), int'(e == 7));
      check($sformatf("satPressS@%0d", e), int'(ifS.outPress), int'(e == 7));
      check($sformatf("satWrapS@%0d", e), int'(ifS.outWrap), 0);
    end
    tick();
    check("wrapOneCycle", int'(ifW.outWrap), 0);
    up = 1'b0;
    repeat (10) tick();
    checkOutput("afterTopBin", 0, 9);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0, 10, 10);
    checkOutput("downWrapBin", 9, 8);
    check("downWrapCnt", wrapCntW, 1);

    // Up and down together from 5 leave the count alone.
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
    clearCounts();
    applyStimulus(1'b1, 1'b1, 1'b0, 10, 10);
    checkOutput("bothBin", 5, 5);
    check("bothPressCnt", pressCntW, 0);

    // Reset three edges into a debounce: immediate clear, held button ignored until re-pressed.
    up = 1'b1;
    repeat (3) tick();
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncRstBin", 0, 0);
    tick();
    rstN = 1'b1;
    clearCounts();
    repeat (30) tick();
    check("heldAfterRstCnt", pressCntW, 0);
    up = 1'b0;
    repeat (15) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
    checkOutput("rePressBin", 1, 1);

    for (int s = 0; s < 400; s++) begin
      up   = $urandom_range(0, 1);
      down = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 12)) tick();
    end
    up   = 1'b0;
    down = 1'b0;
    clr  = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
